// File: rtl/midi_pkg.sv
// Shared MIDI status constants, message-length decode and serialiser FSM states.
// Pure definitions: no timing, no flow control.
package midi_pkg;

  localparam logic [7:0] NOTE_OFF         = 8'h80;
  localparam logic [7:0] NOTE_ON          = 8'h90;
  localparam logic [7:0] CTRL             = 8'hB0;
  localparam logic [7:0] PROG             = 8'hC0;
  localparam logic [7:0] CHPRESS          = 8'hD0;
  localparam logic [7:0] PBEND            = 8'hE0;
  localparam logic [7:0] CLOCK            = 8'hF8;
  localparam logic [7:0] CC_ALL_NOTES_OFF = 8'h7B;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_e;

  // Bytes on the wire for a given status; 0 marks a status this block refuses.
  function automatic logic [1:0] msg_len(input logic [7:0] status);
    logic [1:0] len;
    len = 2'd0;
    if (status >= NOTE_OFF && status < PROG)        len = 2'd3;
    else if (status >= PROG && status < PBEND)      len = 2'd2;
    else if (status >= PBEND && status < 8'hF0)     len = 2'd3;
    else if (status == 8'hF1 || status == 8'hF3)    len = 2'd2;
    else if (status == 8'hF2)                       len = 2'd3;
    else if (status == 8'hF6 || status >= CLOCK)    len = 2'd1;
    return len;
  endfunction

endpackage

// File: rtl/midi_uart_tx_byte.sv
// 8N1 byte serialiser, LSB first; TX falls on the edge that samples i_load.
// i_load is honoured only when idle or in the final stop-bit cycle (o_frame_end).
module midi_uart_tx_byte
  import midi_pkg::*;
#(
  parameter int CLKS_PER_BIT = 1600
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_load,
  input  logic [7:0] i_byte,
  output logic       o_frame_end,
  output logic       o_near_end,
  output logic       o_tx
);

  localparam logic [15:0] TIMER_MAX = 16'(CLKS_PER_BIT - 1);

  tx_state_e   r_state;
  logic [15:0] r_timer;
  logic [2:0]  r_bit;
  logic [7:0]  r_shift;
  logic        r_tx;
  logic        w_tick;

  assign w_tick      = (r_timer == 16'd0);
  assign o_frame_end = (r_state == ST_STOP) && w_tick;
  // One cycle of warning lets the owner retire BUSY as the stop bit ends.
  assign o_near_end  = (r_state == ST_STOP) && (r_timer == 16'd1);
  assign o_tx        = r_tx;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
      r_timer <= 16'd0;
      r_bit   <= 3'd0;
      r_shift <= 8'd0;
      r_tx    <= 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_load) begin
            r_state <= ST_START;
            r_tx    <= 1'b0;
            r_timer <= TIMER_MAX;
            r_shift <= i_byte;
          end
        end
        ST_START: begin
          if (w_tick) begin
            r_state <= ST_DATA;
            r_tx    <= r_shift[0];
            r_shift <= {1'b0, r_shift[7:1]};
            r_bit   <= 3'd0;
            r_timer <= TIMER_MAX;
          end else begin
            r_timer <= r_timer - 16'd1;
          end
        end
        ST_DATA: begin
          if (w_tick) begin
            r_timer <= TIMER_MAX;
            if (r_bit == 3'd7) begin
              r_state <= ST_STOP;
              r_tx    <= 1'b1;
            end else begin
              r_bit   <= r_bit + 3'd1;
              r_tx    <= r_shift[0];
              r_shift <= {1'b0, r_shift[7:1]};
            end
          end else begin
            r_timer <= r_timer - 16'd1;
          end
        end
        ST_STOP: begin
          if (w_tick) begin
            if (i_load) begin
              r_state <= ST_START;
              r_tx    <= 1'b0;
              r_timer <= TIMER_MAX;
              r_shift <= i_byte;
            end else begin
              r_state <= ST_IDLE;
            end
          end else begin
            r_timer <= r_timer - 16'd1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/midi_msg_tx.sv
// MIDI message to UART line: latch on strobe, TX falls one edge later, bytes back-to-back.
// No backpressure: strobes while BUSY or with bad status are dropped (DROP); MIDI_RUNNING_STATUS_EN omits repeated status.
module midi_msg_tx
  import midi_pkg::*;
#(
  parameter int CLK_HZ = 50000000,
  parameter int BAUD   = 31250
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [23:0] MIDI_MSG,
  input  logic        MIDI_MSG_RDY,
  output logic        BUSY,
  output logic        DONE,
  output logic        DROP,
  output logic        TX
);

  localparam int CLKS_PER_BIT = CLK_HZ / BAUD;

  logic [23:0] r_msg;
  logic [1:0]  r_idx;
  logic [1:0]  r_end;
  logic        r_start;
  logic        r_busy;
  logic        r_done;
  logic        r_drop;

  logic [7:0]  w_status;
  logic [1:0]  w_len;
  logic        w_accept;
  logic        w_reject;
  logic        w_skip;
  logic        w_more;
  logic        w_load;
  logic [1:0]  w_load_idx;
  logic [7:0]  w_load_byte;
  logic        w_frame_end;
  logic        w_near_end;

  assign w_status = MIDI_MSG[23:16];
  assign w_len    = msg_len(w_status);
  assign w_accept = MIDI_MSG_RDY && !r_busy && (w_len != 2'd0);
  assign w_reject = MIDI_MSG_RDY && !w_accept;
  assign w_more   = (r_idx != r_end);

`ifdef MIDI_RUNNING_STATUS_EN
  logic [7:0] r_last_status;
  logic       w_chan_voice;

  assign w_chan_voice = (w_status >= NOTE_OFF) && (w_status < 8'hF0);
  assign w_skip       = w_chan_voice && (w_status == r_last_status);

  // Realtime (F8-FF) is transparent to running status; other system messages cancel it.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_last_status <= 8'h00;
    end else if (w_accept) begin
      if (w_chan_voice)          r_last_status <= w_status;
      else if (w_status < CLOCK) r_last_status <= 8'h00;
    end
  end
`else
  assign w_skip = 1'b0;
`endif

  // First byte loads from r_start; later bytes chain in the last stop-bit cycle.
  assign w_load = r_start || (r_busy && w_frame_end && w_more);

  always_comb begin
    w_load_idx  = r_start ? r_idx : (r_idx + 2'd1);
    w_load_byte = r_msg[7:0];
    case (w_load_idx)
      2'd0:    w_load_byte = r_msg[23:16];
      2'd1:    w_load_byte = r_msg[15:8];
      default: w_load_byte = r_msg[7:0];
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_msg   <= 24'd0;
      r_idx   <= 2'd0;
      r_end   <= 2'd0;
      r_start <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_drop  <= 1'b0;
    end else begin
      r_start <= 1'b0;
      r_done  <= 1'b0;
      r_drop  <= w_reject;
      if (w_accept) begin
        r_msg   <= MIDI_MSG;
        r_idx   <= w_skip ? 2'd1 : 2'd0;
        r_end   <= w_len - 2'd1;
        r_start <= 1'b1;
        r_busy  <= 1'b1;
      end else if (r_busy && !r_start) begin
        if (w_frame_end && w_more) r_idx <= r_idx + 2'd1;
        if (w_near_end && !w_more) begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end
      end
    end
  end

  midi_uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_byte (
    .i_clk       (CLK),
    .i_rst       (RST),
    .i_load      (w_load),
    .i_byte      (w_load_byte),
    .o_frame_end (w_frame_end),
    .o_near_end  (w_near_end),
    .o_tx        (TX)
  );

  assign BUSY = r_busy;
  assign DONE = r_done;
  assign DROP = r_drop;

endmodule

// File: tb/tb_midi_msg_tx.sv
// Directed plus randomized bench for midi_msg_tx at 100 clocks per bit.
// Expected bytes/timing come from a message-level model of the MIDI framing rules.
module tb_midi_msg_tx;

  localparam int BIT   = 100;
  localparam int FRAME = 10 * BIT;
`ifdef MIDI_RUNNING_STATUS_EN
  localparam bit RS_EN = 1'b1;
`else
  localparam bit RS_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [23:0] msg = 24'd0;
  logic        msg_rdy = 1'b0;
  logic        busy, done, drop, tx;

  int checks = 0;
  int failures = 0;
  logic [7:0] m_last = 8'h00;

  logic tx_s   [0:3100];
  logic busy_s [0:3100];
  logic done_s [0:3100];
  logic drop_s [0:3100];

  midi_msg_tx #(.CLK_HZ(3125000), .BAUD(31250)) dut (
    .CLK          (clk),
    .RST          (rst),
    .MIDI_MSG     (msg),
    .MIDI_MSG_RDY (msg_rdy),
    .BUSY         (busy),
    .DONE         (done),
    .DROP         (drop),
    .TX           (tx)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int model_len(input logic [7:0] s);
    case (s[7:4])
      4'h8, 4'h9, 4'hA, 4'hB, 4'hE: return 3;
      4'hC, 4'hD:                   return 2;
      4'hF: begin
        case (s[3:0])
          4'h1, 4'h3: return 2;
          4'h2:       return 3;
          4'h6, 4'h8, 4'h9, 4'hA, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF: return 1;
          default:    return 0;
        endcase
      end
      default: return 0;
    endcase
  endfunction

  // Called at a negedge; drives the strobe and watches the whole message.
  task automatic send(input logic [23:0] m, input int inject_k, input int rst_k, input bit chain);
    logic [7:0] st;
    logic [7:0] exp_q[$];
    logic [9:0] got, want;
    int len, nb, donek, last_k, busy_n, dones, drops, zeros_after;
    bit skip;
    st   = m[23:16];
    len  = model_len(st);
    skip = RS_EN && (st >= 8'h80) && (st <= 8'hEF) && (st == m_last);
    if (!skip)   exp_q.push_back(st);
    if (len >= 2) exp_q.push_back(m[15:8]);
    if (len == 3) exp_q.push_back(m[7:0]);
    if (RS_EN) begin
      if (st <= 8'hEF)      m_last = st;
      else if (st <= 8'hF7) m_last = 8'h00;
    end
    nb     = exp_q.size();
    donek  = nb * FRAME;
    last_k = (chain && rst_k < 0) ? donek : donek + 20;
    busy_n = 0; dones = 0; drops = 0; zeros_after = 0;
    msg = m;
    msg_rdy = 1'b1;
    for (int k = 0; k <= last_k; k++) begin
      @(negedge clk);
      tx_s[k] = tx; busy_s[k] = busy; done_s[k] = done; drop_s[k] = drop;
      busy_n += int'(busy);
      dones  += int'(done);
      drops  += int'(drop);
      if (k > donek && !tx) zeros_after++;
      if (rst_k >= 0 && k > rst_k && !tx) zeros_after++;
      msg_rdy = 1'b0;
      rst = 1'b0;
      if (k == inject_k) begin
        msg = {8'h90 | 8'($urandom_range(0, 15)), 16'($urandom)};
        msg_rdy = 1'b1;
      end
      if (k == rst_k) rst = 1'b1;
    end
    check("busy_at_accept", busy_s[0], 1);
    check("tx_fall_next_edge", tx_s[1], 0);
    if (rst_k >= 0) begin
      m_last = 8'h00;
      check("rst_tx_high", tx_s[rst_k + 1], 1);
      check("rst_busy_low", busy_s[rst_k + 1], 0);
      check("rst_no_done", dones, 0);
      check("rst_tx_idle_after", zeros_after, 0);
      nb = rst_k / FRAME;
    end else begin
      check("busy_cycles", busy_n, donek);
      check("done_at_end", done_s[donek], 1);
      check("done_pulses", dones, 1);
      check("busy_low_at_done", busy_s[donek], 0);
      check("drop_pulses", drops, (inject_k >= 0) ? 1 : 0);
      if (inject_k >= 0) check("drop_timing", drop_s[inject_k + 1], 1);
      if (!chain) check("tx_idle_after", zeros_after, 0);
    end
    for (int b = 0; b < nb; b++) begin
      check($sformatf("start_edge_b%0d", b), {tx_s[b * FRAME], tx_s[b * FRAME + 1]}, 2'b10);
      for (int j = 0; j < 10; j++) got[j] = tx_s[1 + b * FRAME + j * BIT + BIT / 2];
      want = {1'b1, exp_q[b], 1'b0};
      check($sformatf("frame_b%0d", b), got, want);
    end
  endtask

  task automatic drop_only(input logic [23:0] m);
    int bad;
    msg = m;
    msg_rdy = 1'b1;
    @(negedge clk);
    msg_rdy = 1'b0;
    check("unsup_drop", drop, 1);
    check("unsup_busy", busy, 0);
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (!tx || busy || drop || done) bad++;
    end
    check("unsup_quiet", bad, 0);
  endtask

  initial begin
    logic [7:0] cv_types [0:6];
    logic [7:0] sys_types [0:7];
    logic [7:0] bad_types [0:4];
    logic [7:0] st;
    int r;
    cv_types  = '{8'h80, 8'h90, 8'hA0, 8'hB0, 8'hC0, 8'hD0, 8'hE0};
    sys_types = '{8'hF1, 8'hF2, 8'hF3, 8'hF6, 8'hF8, 8'hFA, 8'hFC, 8'hFF};
    bad_types = '{8'h3C, 8'hF0, 8'hF4, 8'hF5, 8'hF7};

    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_tx", tx, 1);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_drop", drop, 0);
    rst = 1'b0;
    m_last = 8'h00;
    @(negedge clk);

    send(24'h903C64, -1, -1, 1'b0);
    send({16'hC507, 8'($urandom)}, -1, -1, 1'b0);
    send({8'hF8, 16'($urandom)}, -1, -1, 1'b0);
    drop_only(24'h3C0000);

    send({8'hB0 | 8'($urandom_range(0, 15)), 16'($urandom)}, 500, -1, 1'b1);
    send({8'hE0 | 8'($urandom_range(0, 15)), 16'($urandom)}, -1, -1, 1'b0);

    send(24'hA14020, -1, 1250, 1'b0);
    send(24'h803C00, -1, -1, 1'b0);

    send(24'h903C64, -1, -1, 1'b0);
    send(24'h904064, -1, -1, 1'b0);
    send({8'hF8, 16'($urandom)}, -1, -1, 1'b0);
    send(24'h904364, -1, -1, 1'b0);
    send(24'hF20000, -1, -1, 1'b0);
    send(24'h903C00, -1, -1, 1'b0);

    for (int i = 0; i < 6; i++) begin
      r = $urandom_range(0, 9);
      if (r <= 6)      st = cv_types[r] | 8'($urandom_range(0, 15));
      else if (r == 7) st = sys_types[$urandom_range(0, 7)];
      else if (r == 8) st = bad_types[$urandom_range(0, 4)];
      else             st = (m_last != 8'h00) ? m_last : 8'h95;
      if (model_len(st) == 0) drop_only({st, 16'($urandom)});
      else                    send({st, 16'($urandom)}, -1, -1, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
